// File: rtl/game_ctrl.sv
// game_ctrl: round sequencer producing start/over strobes and tracking lives, bonus and score.
// Define GAME_PAUSE_EN to add the btn_pause input and the PAUSED state.
module game_ctrl #(
  parameter int LIVES        = 3,
  parameter int BONUS_INIT   = 5000,
  parameter int BONUS_STEP   = 100,
  parameter int BONUS_PERIOD = 120,
  parameter int DEATH_FRAMES = 90,
  parameter int WIN_FRAMES   = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        btn_start,
  input  logic        hit,
  input  logic        reach,
`ifdef GAME_PAUSE_EN
  input  logic        btn_pause,
`endif
  output logic        start,
  output logic        over,
  output logic [2:0]  state,
  output logic [2:0]  lives,
  output logic [12:0] bonus,
  output logic [15:0] score
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, PLAYING = 3'd1, DYING = 3'd2, WIN = 3'd3, GAMEOVER = 3'd4
`ifdef GAME_PAUSE_EN
    , PAUSED = 3'd5
`endif
  } state_t;
  state_t      cur, nxt;
  logic        start_n, over_n, prev_start, start_edge, frames_done, period_last;
  logic [2:0]  lives_n;
  logic [12:0] bonus_n;
  logic [15:0] score_n;
  logic [7:0]  period, period_n, frame, frame_n;
  logic [16:0] sum;
`ifdef GAME_PAUSE_EN
  logic prev_pause, pause_edge;
  assign pause_edge = btn_pause & ~prev_pause;
  always_ff @(posedge clk) prev_pause <= rst ? 1'b0 : btn_pause;
`endif
  assign state       = cur;
  assign start_edge  = btn_start & ~prev_start;
  assign sum         = {1'b0, score} + 17'(bonus);
  assign period_last = period == 8'(BONUS_PERIOD - 1);
  assign frames_done = tick && (frame == ((cur == DYING) ? 8'(DEATH_FRAMES - 1) : 8'(WIN_FRAMES - 1)));
  always_comb begin
    nxt      = cur;
    start_n  = 1'b0;
    over_n   = 1'b0;
    lives_n  = lives;
    bonus_n  = bonus;
    score_n  = score;
    period_n = period;
    frame_n  = frame;
    case (cur)
      IDLE, GAMEOVER:
        if (start_edge) begin
          nxt      = PLAYING;
          start_n  = 1'b1;
          lives_n  = 3'(LIVES);
          score_n  = '0;
          bonus_n  = 13'(BONUS_INIT);
          period_n = '0;
        end
      PLAYING:
        // hit beats reach; an exhausted bonus only kills when neither event fired
        if (hit || (!reach && bonus == '0)) begin
          nxt     = DYING;
          over_n  = 1'b1;
          lives_n = lives - 3'(lives != 3'd0);
        end else if (reach) begin
          nxt     = WIN;
          over_n  = 1'b1;
          score_n = sum[16] ? '1 : sum[15:0];
        end
`ifdef GAME_PAUSE_EN
        else if (pause_edge) nxt = PAUSED;
`endif
        else if (tick) begin
          period_n = period_last ? '0 : period + 8'd1;
          bonus_n  = !period_last ? bonus : (bonus >= 13'(BONUS_STEP)) ? bonus - 13'(BONUS_STEP) : '0;
        end
      DYING, WIN:
        if (frames_done) begin
          if (cur == DYING && lives == '0) nxt = GAMEOVER;
          else begin
            nxt      = PLAYING;
            start_n  = 1'b1;
            bonus_n  = 13'(BONUS_INIT);
            period_n = '0;
          end
        end else if (tick) frame_n = frame + 8'd1;
`ifdef GAME_PAUSE_EN
      PAUSED: if (pause_edge) nxt = PLAYING;
`endif
      default: nxt = IDLE;
    endcase
    if (nxt != cur) frame_n = '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cur        <= IDLE;
      start      <= 1'b0;
      over       <= 1'b0;
      lives      <= 3'(LIVES);
      bonus      <= 13'(BONUS_INIT);
      score      <= '0;
      period     <= '0;
      frame      <= '0;
      prev_start <= 1'b0;
    end else begin
      cur        <= nxt;
      start      <= start_n;
      over       <= over_n;
      lives      <= lives_n;
      bonus      <= bonus_n;
      score      <= score_n;
      period     <= period_n;
      frame      <= frame_n;
      prev_start <= btn_start;
    end
  end
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: scoreboard bench comparing game_ctrl against a round-level reference model.
module tb_game_ctrl;
  localparam int LIVES = 3, BONUS_INIT = 5000, BONUS_STEP = 100;
  localparam int BONUS_PERIOD = 2, DEATH_FRAMES = 4, WIN_FRAMES = 4;
`ifdef GAME_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, tick = 1'b0, btn_start = 1'b0, hit = 1'b0, reach = 1'b0, btn_pause = 1'b0;
  logic start, over;
  logic [2:0] state, lives;
  logic [12:0] bonus;
  logic [15:0] score;
  typedef struct packed {
    logic        start;
    logic        over;
    logic [2:0]  state;
    logic [2:0]  lives;
    logic [12:0] bonus;
    logic [15:0] score;
  } obs_t;
  obs_t exp_q[$], ev_q[$];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  game_ctrl #(
    .LIVES(LIVES), .BONUS_INIT(BONUS_INIT), .BONUS_STEP(BONUS_STEP),
    .BONUS_PERIOD(BONUS_PERIOD), .DEATH_FRAMES(DEATH_FRAMES), .WIN_FRAMES(WIN_FRAMES)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .btn_start(btn_start), .hit(hit), .reach(reach),
`ifdef GAME_PAUSE_EN
    .btn_pause(btn_pause),
`endif
    .start(start), .over(over), .state(state), .lives(lives), .bonus(bonus), .score(score)
  );
  // Reference model: phases by their visible state number, bonus derived from ticks played this round
  int m_phase, m_lives, m_score, m_round_ticks, m_phase_ticks;
  bit m_prev_s, m_prev_p, m_start, m_over;
  function automatic int bonus_of(input int rt);
    int b;
    b = BONUS_INIT - BONUS_STEP * (rt / BONUS_PERIOD);
    return (b < 0) ? 0 : b;
  endfunction
  task automatic enter_round();
    m_phase = 1;
    m_round_ticks = 0;
    m_start = 1'b1;
  endtask
  task automatic step();
    bit se, pe;
    int b;
    obs_t e;
    m_start = 1'b0;
    m_over = 1'b0;
    if (rst) begin
      m_phase = 0; m_lives = LIVES; m_score = 0; m_round_ticks = 0; m_phase_ticks = 0;
      m_prev_s = 1'b0; m_prev_p = 1'b0;
    end else begin
      se = btn_start && !m_prev_s;
      pe = btn_pause && !m_prev_p;
      m_prev_s = btn_start;
      m_prev_p = btn_pause;
      b = bonus_of(m_round_ticks);
      if (m_phase == 0 || m_phase == 4) begin
        if (se) begin
          m_lives = LIVES;
          m_score = 0;
          enter_round();
        end
      end else if (m_phase == 1) begin
        if (hit || (!reach && b == 0)) begin
          m_phase = 2; m_phase_ticks = 0; m_over = 1'b1;
          m_lives = (m_lives > 0) ? m_lives - 1 : 0;
        end else if (reach) begin
          m_phase = 3; m_phase_ticks = 0; m_over = 1'b1;
          m_score = (m_score + b > 65535) ? 65535 : m_score + b;
        end else if (PAUSE_EN && pe) m_phase = 5;
        else if (tick) m_round_ticks++;
      end else if (m_phase == 2 || m_phase == 3) begin
        if (tick) begin
          m_phase_ticks++;
          if (m_phase_ticks == ((m_phase == 2) ? DEATH_FRAMES : WIN_FRAMES)) begin
            if (m_phase == 2 && m_lives == 0) m_phase = 4;
            else enter_round();
          end
        end
      end else if (m_phase == 5) begin
        if (pe) m_phase = 1;
      end
    end
    e.start = m_start;
    e.over = m_over;
    e.state = 3'(m_phase);
    e.lives = 3'(m_lives);
    e.bonus = 13'(bonus_of(m_round_ticks));
    e.score = 16'(m_score);
    exp_q.push_back(e);
    if (m_start || m_over) ev_q.push_back(e);
  endtask
  task automatic cyc(input logic t, input logic h, input logic r);
    tick = t;
    hit = h;
    reach = r;
    step();
    @(negedge clk);
  endtask
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      a = {start, over, state, lives, bonus, score};
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL status t=%0t got start=%0b over=%0b state=%0d lives=%0d bonus=%0d score=%0d want start=%0b over=%0b state=%0d lives=%0d bonus=%0d score=%0d",
                   $time, a.start, a.over, a.state, a.lives, a.bonus, a.score, e.start, e.over, e.state, e.lives, e.bonus, e.score);
        end
      end
      if (start || over) begin
        checks++;
        if (ev_q.size() == 0) begin
          failures++;
          $display("FAIL pulse t=%0t got start=%0b over=%0b state=%0d want no pulse", $time, start, over, state);
        end else begin
          e = ev_q.pop_front();
          if (a !== e) begin
            failures++;
            $display("FAIL pulse t=%0t got start=%0b over=%0b state=%0d lives=%0d score=%0d want start=%0b over=%0b state=%0d lives=%0d score=%0d",
                     $time, a.start, a.over, a.state, a.lives, a.score, e.start, e.over, e.state, e.lives, e.score);
          end
        end
      end
    end
  end
  initial begin
    @(negedge clk);
    rst = 1'b1;
    repeat (2) cyc(0, 0, 0);
    rst = 1'b0;
    btn_start = 1'b1;
    repeat (10) cyc(0, 0, 0);
    btn_start = 1'b0;
    repeat (6) cyc(1, 0, 0);
    cyc(0, 1, 0);
    repeat (4) begin cyc(1, 0, 0); cyc(0, 0, 0); end
    repeat (4) cyc(1, 0, 0);
    cyc(0, 0, 1);
    repeat (4) cyc(1, 0, 0);
    cyc(0, 0, 0);
    repeat (3) begin
      cyc(0, 1, 1);
      repeat (5) cyc(1, 0, 0);
    end
    btn_start = 1'b1;
    cyc(0, 0, 0);
    btn_start = 1'b0;
    repeat (103) cyc(1, 0, 0);
    cyc(1, 0, 0);
    rst = 1'b1;
    cyc(1, 0, 0);
    rst = 1'b0;
    repeat (2) cyc(0, 0, 0);
    btn_start = 1'b1;
    cyc(0, 0, 0);
    btn_start = 1'b0;
    repeat (14) begin
      cyc(1, 0, 1);
      repeat (4) cyc(1, 0, 0);
    end
    btn_pause = 1'b1;
    cyc(0, 0, 0);
    repeat (20) cyc(1, 0, 0);
    cyc(1, 1, 1);
    btn_pause = 1'b0;
    cyc(0, 0, 0);
    btn_start = 1'b1;
    cyc(0, 0, 0);
    btn_start = 1'b0;
    btn_pause = 1'b1;
    cyc(1, 0, 0);
    repeat (3) cyc(1, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 19) == 0) btn_start = ~btn_start;
      if ($urandom_range(0, 29) == 0) btn_pause = ~btn_pause;
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 39) == 0));
    end
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0 || ev_q.size() != 0) begin
      failures++;
      $display("FAIL drain got pending_status=%0d pending_pulses=%0d want 0 and 0", exp_q.size(), ev_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Top-level round sequencer sitting directly upstream of the character/NPC blocks. Generates their one-cycle `start` and `over` strobes.
- Tracks lives, the bonus countdown timer and the score.
- Decides death, win and game-over from collision and goal events supplied by the player/barrel logic.
- All timing is counted in frame ticks (`tick`, one-cycle pulse per video frame), not raw clocks.

Parameters:
- LIVES, 3: lives loaded at game start; 2..7.
- BONUS_INIT, 5000: bonus value loaded at each round start; must fit 13 bits.
- BONUS_STEP, 100: amount subtracted per bonus period.
- BONUS_PERIOD, 120: ticks between bonus decrements; 1..255.
- DEATH_FRAMES, 90: ticks spent in DYING; 1..255.
- WIN_FRAMES, 120: ticks spent in WIN; 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- tick  in  1  frame strobe, one clk wide
- btn_start  in  1  start button level, already debounced; rising edge used
- hit  in  1  player collision pulse
- reach  in  1  player reached goal pulse
- btn_pause  in  1  pause button level; rising edge used; only present with GAME_PAUSE_EN
- start  out  1  one-cycle pulse on every entry to PLAYING
- over  out  1  one-cycle pulse on every exit from PLAYING to DYING or WIN
- state  out  3  IDLE=0, PLAYING=1, DYING=2, WIN=3, GAMEOVER=4, PAUSED=5
- lives  out  3  remaining lives
- bonus  out  13  current bonus
- score  out  16  accumulated score

Behaviour:
- Reset (sync, overrides everything):
  - state=IDLE; start=over=0; lives=LIVES; bonus=BONUS_INIT; score=0.
  - Clears the tick, frame and button-edge registers.
- Edge detect: `btn_start` and `btn_pause` are registered; edge = current & ~previous. A held button produces one edge only.
- IDLE, start edge: go to PLAYING next cycle. Load lives=LIVES, score=0, bonus=BONUS_INIT. Clear the period counter. `start` is high in the same cycle state first reads PLAYING.
- PLAYING:
  - Each `tick` increments the period counter.
  - When the counter reaches BONUS_PERIOD-1 with `tick` high: counter returns to 0 and bonus = bonus-BONUS_STEP, saturating at 0.
  - Exit priority within one cycle: hit > reach > timeout. Timeout means bonus is 0 at the start of the cycle.
  - hit or timeout: go to DYING, lives decrements (no underflow below 0), `over` pulses.
  - reach: go to WIN, score = score+bonus (saturating at 65535), `over` pulses.
- DYING:
  - Counts DEATH_FRAMES ticks; hit and reach are ignored.
  - At the end: lives==0 goes to GAMEOVER; otherwise go to PLAYING with bonus=BONUS_INIT, period counter cleared, `start` pulsed.
- WIN:
  - Counts WIN_FRAMES ticks.
  - At the end: go to PLAYING with bonus=BONUS_INIT, `start` pulsed. Lives and score are kept.
- GAMEOVER: holds lives, score and bonus. A start edge behaves exactly like the IDLE start edge.
- Pulse width: `start` and `over` are exactly one clk wide. Never both high in the same cycle.
- Frame counter: one 8-bit counter shared by DYING and WIN; cleared on every state change.
- A `tick` coinciding with a state change is not counted in the new state.
- Reset asserted mid-round forces IDLE next cycle. No `over` pulse is produced; downstream blocks see `rst` directly.

Optional Feature:
- Macro: GAME_PAUSE_EN.
- With the macro defined:
  - A `btn_pause` edge in PLAYING goes to PAUSED. Bonus, period counter, lives and score are frozen; hit and reach are ignored.
  - A `btn_pause` edge in PAUSED returns to PLAYING. No `start` pulse is issued.
  - A start edge in PAUSED is ignored.
- Without the macro: the `btn_pause` port and the PAUSED state are absent; state value 5 is never produced.

Test Plan (LIVES=3, BONUS_INIT=5000, BONUS_STEP=100, BONUS_PERIOD=2, DEATH_FRAMES=4, WIN_FRAMES=4):
- Reset, then hold `btn_start` high for 10 clk -> exactly one `start` pulse; state=1; lives=3; bonus=5000.
- In PLAYING, 6 ticks -> bonus=4700. Then `hit` -> `over` pulse, state=2, lives=2. After 4 ticks -> `start` pulse, state=1, bonus=5000.
- `reach` with bonus=4800 and score=0 -> state=3, score=4800, `over` pulse. After 4 ticks -> state=1, lives unchanged.
- `hit` and `reach` in the same cycle -> DYING, score unchanged. Repeat until lives=0 -> state=4. Then a start edge -> state=1, lives=3, score=0.
- No events for 100 ticks -> bonus reaches 0, next cycle goes to DYING with lives decremented. Separately, `rst` mid-DYING -> state=0 next cycle, no `start` or `over` pulse.
- GAME_PAUSE_EN: pause edge -> state=5. 20 ticks plus a `hit` -> bonus and lives unchanged. Pause edge -> state=1 with no `start` pulse.
